// File: rtl/scoreboard_warp_param.sv
// Per-warp register scoreboard: tracks in-flight instructions and flags RAW/WAW/WAR hazards.
// Optional per-entry age watchdog enabled by defining SCB_WATCHDOG_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_FREE   | entry unused, available for allocation
// ST_REPLAY | LW/SW waiting on memory replay completion
// ST_WB     | waiting on branch resolution or CDB write-back
module scoreboard_warp_param #(
   parameter int NUM_ENTRIES  = 4,
   parameter int LOG_ENTRIES  = $clog2(NUM_ENTRIES),
   parameter int REG_ID_WIDTH = 5,
   parameter int WDOG_LIMIT   = 1023
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alloc_valid,
   input  logic [REG_ID_WIDTH-1:0] src1,
   input  logic [REG_ID_WIDTH-1:0] src2,
   input  logic [REG_ID_WIDTH-1:0] dst,
   input  logic                    src1_valid,
   input  logic                    src2_valid,
   input  logic                    dst_valid,
   input  logic                    replayable,
   output logic [LOG_ENTRIES-1:0]  alloc_id,
   input  logic                    replay_complete,
   input  logic [LOG_ENTRIES-1:0]  replay_complete_id,
   input  logic                    replay_sw_lwbar,
   input  logic                    clear_valid_br,
   input  logic [LOG_ENTRIES-1:0]  clear_id_br,
   input  logic                    clear_valid_regwr,
   input  logic [LOG_ENTRIES-1:0]  clear_id_regwr,
   input  logic                    flush,
   output logic                    full,
   output logic                    empty,
   output logic                    dependent,
   output logic [LOG_ENTRIES:0]    occupancy,
   output logic                    overflow_err,
   output logic                    wdog_err,
   output logic [LOG_ENTRIES-1:0]  wdog_id
);

   localparam int OCC_W = LOG_ENTRIES + 1;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_REPLAY = 2'd1,
      ST_WB     = 2'd2
   } ent_state_e;

   if (NUM_ENTRIES < 2 || WDOG_LIMIT < 1) begin : g_bad_param
      $error("scoreboard_warp_param: NUM_ENTRIES must be >= 2 and WDOG_LIMIT >= 1");
   end

   ent_state_e                state_q  [NUM_ENTRIES];
   ent_state_e                state_cv [NUM_ENTRIES];
   ent_state_e                state_d  [NUM_ENTRIES];
   logic [REG_ID_WIDTH-1:0]   src1_q   [NUM_ENTRIES];
   logic [REG_ID_WIDTH-1:0]   src2_q   [NUM_ENTRIES];
   logic [REG_ID_WIDTH-1:0]   dst_q    [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0]    src1_v_q;
   logic [NUM_ENTRIES-1:0]    src2_v_q;
   logic [NUM_ENTRIES-1:0]    dst_v_q;

   logic [NUM_ENTRIES-1:0]    hit_br;
   logic [NUM_ENTRIES-1:0]    hit_rw;
   logic [NUM_ENTRIES-1:0]    hit_rc;
   logic                      found;
   logic                      alloc_ok;
   logic [OCC_W-1:0]          occ_d;

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         hit_br[i] = clear_valid_br    && (clear_id_br        == LOG_ENTRIES'(i));
         hit_rw[i] = clear_valid_regwr && (clear_id_regwr     == LOG_ENTRIES'(i));
         hit_rc[i] = replay_complete   && (replay_complete_id == LOG_ENTRIES'(i));
      end
   end

   // Cleared view: a REPLAY entry only yields to a write-back that arrives with its LW completion.
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         state_cv[i] = state_q[i];
         if (state_q[i] == ST_WB && (hit_br[i] || hit_rw[i]))
            state_cv[i] = ST_FREE;
         if (state_q[i] == ST_REPLAY && hit_rw[i] && hit_rc[i] && !replay_sw_lwbar)
            state_cv[i] = ST_FREE;
      end
   end

   always_comb begin
      found     = 1'b0;
      alloc_id  = '0;
      empty     = 1'b1;
      dependent = 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (state_cv[i] == ST_FREE) begin
            if (!found) begin
               found    = 1'b1;
               alloc_id = LOG_ENTRIES'(i);
            end
         end else begin
            empty = 1'b0;
            if (src1_valid && dst_v_q[i] && src1 == dst_q[i])
               dependent = 1'b1;
            if (src2_valid && dst_v_q[i] && src2 == dst_q[i])
               dependent = 1'b1;
            if (dst_valid && dst_v_q[i] && dst == dst_q[i])
               dependent = 1'b1;
            if (dst_valid && ((src1_v_q[i] && dst == src1_q[i]) ||
                              (src2_v_q[i] && dst == src2_q[i])))
               dependent = 1'b1;
         end
      end
      full = !found;
   end

   assign alloc_ok = alloc_valid && !full && !flush;

   always_comb begin
      occ_d = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         state_d[i] = state_cv[i];
         if (state_cv[i] == ST_REPLAY && hit_rc[i])
            state_d[i] = replay_sw_lwbar ? ST_FREE : ST_WB;
         if (alloc_ok && alloc_id == LOG_ENTRIES'(i))
            state_d[i] = replayable ? ST_REPLAY : ST_WB;
         if (flush)
            state_d[i] = ST_FREE;
         occ_d = occ_d + OCC_W'(state_d[i] != ST_FREE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_q[i] <= ST_FREE;
            src1_q[i]  <= '0;
            src2_q[i]  <= '0;
            dst_q[i]   <= '0;
         end
         src1_v_q     <= '0;
         src2_v_q     <= '0;
         dst_v_q      <= '0;
         occupancy    <= '0;
         overflow_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_q[i] <= state_d[i];
            if (alloc_ok && alloc_id == LOG_ENTRIES'(i)) begin
               src1_q[i]   <= src1;
               src2_q[i]   <= src2;
               dst_q[i]    <= dst;
               src1_v_q[i] <= src1_valid;
               src2_v_q[i] <= src2_valid;
               dst_v_q[i]  <= dst_valid;
            end
         end
         occupancy <= occ_d;
         if (alloc_valid && full && !flush)
            overflow_err <= 1'b1;
      end
   end

`ifdef SCB_WATCHDOG_EN
   localparam int AGE_W = $clog2(WDOG_LIMIT + 1);

   logic [AGE_W-1:0]       age_q [NUM_ENTRIES];
   logic                   wdog_hit;
   logic [LOG_ENTRIES-1:0] wdog_hit_id;

   always_comb begin
      wdog_hit    = 1'b0;
      wdog_hit_id = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!wdog_hit && age_q[i] == AGE_W'(WDOG_LIMIT)) begin
            wdog_hit    = 1'b1;
            wdog_hit_id = LOG_ENTRIES'(i);
         end
      end
   end

   // Ages saturate at the limit; the error and the first offending index are sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++)
            age_q[i] <= '0;
         wdog_err <= 1'b0;
         wdog_id  <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc_ok && alloc_id == LOG_ENTRIES'(i))
               age_q[i] <= '0;
            else if (state_q[i] != ST_FREE && age_q[i] != AGE_W'(WDOG_LIMIT))
               age_q[i] <= age_q[i] + AGE_W'(1);
         end
         if (!wdog_err && wdog_hit) begin
            wdog_err <= 1'b1;
            wdog_id  <= wdog_hit_id;
         end
      end
   end
`else
   assign wdog_err = 1'b0;
   assign wdog_id  = '0;
`endif

endmodule
